// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C master arbiter: FSM state encoding, operation kind, size limit.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    localparam int unsigned I2C_ARB_MAX_N = 8;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending port searching from last+1 modulo N.
module i2c_rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] next
);

    logic [IW-1:0] cand;

    // Scan farthest-first so the nearest pending port after 'last' overwrites earlier hits.
    always_comb begin
        valid = 1'b0;
        next  = last;
        cand  = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            cand = IW'((32'(last) + i) % N);
            if (pending[cand]) begin
                valid = 1'b1;
                next  = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master_top between N requesters.
module i2c_master_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    cl_rd_req,
    input  logic [N-1:0]    cl_wr_req,
    input  logic [N-1:0]    cl_addr_2byte,
    input  logic [8*N-1:0]  cl_dev_addr,
    input  logic [16*N-1:0] cl_reg_addr,
    input  logic [8*N-1:0]  cl_wdata,
    output logic [N-1:0]    cl_ack,
    output logic [7:0]      cl_rdata,
    output logic            cl_error,
    output logic            busy,
    output logic [IW-1:0]   grant_idx,
    output logic            i2c_addr_2byte,
    output logic [7:0]      i2c_slave_dev_addr,
    output logic [15:0]     i2c_slave_reg_addr,
    output logic [7:0]      i2c_write_data,
    output logic            i2c_read_req,
    output logic            i2c_write_req,
    input  logic            i2c_read_req_ack,
    input  logic            i2c_write_req_ack,
    input  logic [7:0]      i2c_read_data,
    input  logic            error
);
    import i2c_arb_pkg::*;

    arb_state_t    state, state_nxt;
    arb_op_t       op;
    logic [N-1:0]  pending;
    logic          master_ack;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    assign pending    = cl_rd_req | cl_wr_req;
    assign master_ack = i2c_read_req_ack | i2c_write_req_ack;

    i2c_rr_pick #(.N(N)) u_pick (
        .pending (pending),
        .last    (grant_idx),
        .valid   (pick_valid),
        .next    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (master_ack) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_GAP;
            ST_GAP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign cl_ack = (state == ST_DONE) ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx          <= IW'(N - 1);
            op                 <= OP_RD;
            cl_rdata           <= '0;
            cl_error           <= 1'b0;
            i2c_addr_2byte     <= 1'b0;
            i2c_slave_dev_addr <= '0;
            i2c_slave_reg_addr <= '0;
            i2c_write_data     <= '0;
            i2c_read_req       <= 1'b0;
            i2c_write_req      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx          <= pick_idx;
                        op                 <= cl_wr_req[pick_idx] ? OP_WR : OP_RD;
                        i2c_write_req      <= cl_wr_req[pick_idx];
                        i2c_read_req       <= !cl_wr_req[pick_idx];
                        i2c_addr_2byte     <= cl_addr_2byte[pick_idx];
                        i2c_slave_dev_addr <= cl_dev_addr[pick_idx*8 +: 8];
                        i2c_slave_reg_addr <= cl_reg_addr[pick_idx*16 +: 16];
                        i2c_write_data     <= cl_wdata[pick_idx*8 +: 8];
                    end
                end
                ST_ISSUE: begin
                    if (master_ack) begin
                        i2c_read_req  <= 1'b0;
                        i2c_write_req <= 1'b0;
                        cl_error      <= error;
                        if (op == OP_RD) cl_rdata <= i2c_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter that shares one `i2c_master_top` between `N` independent requesters (EEPROM access, sensor poller, config loader). It latches the granted requester's command, drives the master's level request/ack handshake, and returns read data and the error flag to the requester with a one-cycle ack pulse. It sits directly between client logic and `i2c_master_top`.

## Interface
- `N`, 2: number of requesters (2..8).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cl_rd_req`  in  N  per-port read request (level).
- `cl_wr_req`  in  N  per-port write request (level).
- `cl_addr_2byte`  in  N  per-port 16-bit register address select.
- `cl_dev_addr`  in  8*N  per-port device address; port p at [8p+7:8p].
- `cl_reg_addr`  in  16*N  per-port register address.
- `cl_wdata`  in  8*N  per-port write data.
- `cl_ack`  out  N  one-cycle completion pulse to the owning port; reset 0.
- `cl_rdata`  out  8  read data, valid in the `cl_ack` cycle, held until next completion; reset 8'h00.
- `cl_error`  out  1  NACK flag, same validity as `cl_rdata`; reset 0.
- `busy`  out  1  high in any state except IDLE; reset 0.
- `grant_idx`  out  $clog2(N)  port currently or last served; reset N-1.
- `i2c_addr_2byte`, `i2c_slave_dev_addr`[8], `i2c_slave_reg_addr`[16], `i2c_write_data`[8]  out  master command fields, registered; reset 0.
- `i2c_read_req`, `i2c_write_req`  out  1  master request levels; reset 0.
- `i2c_read_req_ack`, `i2c_write_req_ack`  in  1  master completion pulses.
- `i2c_read_data`  in  8  master read data.
- `error`  in  1  master error flag.

## Operation
- States: IDLE, ISSUE, DONE, GAP.
- IDLE: port p is pending when `cl_rd_req[p] | cl_wr_req[p]`. With any pending port, grant the first pending port searching from `grant_idx+1` modulo N. Latch that port's dev/reg/2byte/wdata into the `i2c_*` command registers. Set exactly one of `i2c_write_req`/`i2c_read_req`; write wins if a port asserts both. Go to ISSUE.
- ISSUE: hold the request and command fields stable. On `i2c_read_req_ack | i2c_write_req_ack`, do all of the following and go to DONE:
  - clear both requests;
  - capture `cl_error <= error`;
  - capture `cl_rdata <= i2c_read_data` for reads only; writes leave `cl_rdata` unchanged.
- DONE: `cl_ack[grant_idx]`=1 for this cycle only. Go to GAP.
- GAP: one idle cycle so the master passes its WAIT state back to IDLE. Go to IDLE.
- Client rule: hold the request and arguments until `cl_ack`, then deassert within one cycle. A request still high in the IDLE cycle after its ack is a new transaction.
- A port withdrawing its request before grant is not served. Withdrawal after grant is ignored; the transaction completes and `cl_ack` still fires.
- Acks arriving outside ISSUE are ignored. No timeout: the master always terminates.
- Reset mid-transaction returns all outputs to reset values immediately. The master is reset by the same system reset.

## Timing
- Request seen high at edge 0 → `i2c_*_req` high from edge 1.
- Master ack high in cycle k → `cl_ack` high in cycle k+1 → GAP in k+2 → IDLE in k+3 → earliest next `i2c_*_req` at k+4.
- Minimum spacing between master requests: 3 cycles after the ack cycle.
- Fairness: a continuously pending port waits at most N-1 transactions.

## Structure
- Package `i2c_arb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, DONE=2, GAP=3);
  - op type (OP_RD, OP_WR);
  - `I2C_ARB_MAX_N`=8.
- Sub-module `i2c_rr_pick`: combinational round-robin priority picker. Inputs: pending vector and last index. Outputs: valid and next index.

## Test plan
- Single write: port 0, dev 8'hA0, reg 16'h0010, 1-byte address, data 8'h5A. Expect `i2c_write_req` for the whole ISSUE phase with exactly those fields, one `cl_ack[0]` pulse, `cl_error`=0, `cl_rdata` unchanged.
- Read, 2-byte address: port 1, reg 16'h1234, model returns 8'hC3. Expect `cl_rdata`=8'hC3 in the `cl_ack[1]` cycle. Master ack in cycle k produces `cl_ack` exactly in k+1.
- Contention with N=3: all ports request continuously. Grant order must be 0,1,2,0,1,2. Every grant waits at least 3 cycles after the previous master ack.
- NACK: model raises `error` through the write ack. Expect `cl_error`=1 with `cl_ack`. A following successful read gives `cl_error`=0.
- Both `rd` and `wr` high on port 2 → write issued. Port 1 withdraws before grant → never acked.
- `rst_n` low during ISSUE. Expect all outputs at reset values asynchronously. After release, the first grant goes to port 0.
